// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared widths, ROM size, NOP encoding and fetch FSM states
package fetch_stage_pkg;
  localparam int PC_W = 16;
  localparam int INSTR_W = 16;
  localparam int IMEM_BYTES = 32;
  localparam logic [INSTR_W-1:0] INSTR_NOP = '0;
  typedef enum logic {FETCH_RUN = 1'b0, FETCH_HALT = 1'b1} fetch_state_e;
endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// if_id_reg: IF/ID pipeline register with load, bubble and hold controls
module if_id_reg
  import fetch_stage_pkg::*;
#(
  parameter int PW = PC_W,
  parameter int IW = INSTR_W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_i,
  input  logic          bubble_i,
  input  logic [IW-1:0] instr_i,
  input  logic [PW-1:0] pc_i,
  input  logic [PW-1:0] pc_plus2_i,
  output logic          valid_o,
  output logic [IW-1:0] instr_o,
  output logic [PW-1:0] pc_o,
  output logic [PW-1:0] pc_plus2_o
);
  logic          valid_q, valid_d;
  logic [IW-1:0] instr_q, instr_d;
  logic [PW-1:0] pc_q, pc_d, pc2_q, pc2_d;
  // load captures a new word; bubble clears valid/instr but keeps the pc fields
  always_comb begin
    valid_d = load_i ? 1'b1 : (bubble_i ? 1'b0 : valid_q);
    instr_d = load_i ? instr_i : (bubble_i ? IW'(INSTR_NOP) : instr_q);
    pc_d    = load_i ? pc_i : pc_q;
    pc2_d   = load_i ? pc_plus2_i : pc2_q;
  end
  // register update with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
      pc2_q   <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
      pc2_q   <= pc2_d;
    end
  end
  assign valid_o    = valid_q;
  assign instr_o    = instr_q;
  assign pc_o       = pc_q;
  assign pc_plus2_o = pc2_q;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC register, RUN/HALT fetch FSM, fetch counter and IF/ID register
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int              PW         = PC_W,
  parameter int              IW         = INSTR_W,
  parameter logic [PW-1:0]   RESET_PC   = '0,
  parameter int              IMEM_BYTES = fetch_stage_pkg::IMEM_BYTES
) (
  input  logic          clk,
  input  logic          reset,
  output logic [PW-1:0] imem_pc,
  input  logic [IW-1:0] imem_instr,
  input  logic          stall,
  input  logic          redirect_valid,
  input  logic [PW-1:0] redirect_pc,
  output logic          if_id_valid,
  output logic [IW-1:0] if_id_instr,
  output logic [PW-1:0] if_id_pc,
  output logic [PW-1:0] if_id_pc_plus2,
  output logic          halted,
  output logic [15:0]   fetch_count
);
  fetch_state_e  state_q, state_d;
  logic [PW-1:0] pc_q, pc_d;
  logic [15:0]   fetch_count_q, fetch_count_d;
  logic          load, bubble;
  logic [PW-1:0] target, pc_plus2;
  logic          in_range;
  assign target   = {redirect_pc[PW-1:1], 1'b0};
  assign pc_plus2 = pc_q + PW'(2);
  assign in_range = pc_q < PW'(IMEM_BYTES);
  // next state: redirect beats stall beats advance; HALT ignores stall and waits for a redirect
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    fetch_count_d = fetch_count_q;
    load          = 1'b0;
    bubble        = 1'b0;
    if (state_q == FETCH_HALT) begin
      bubble = 1'b1;
      if (redirect_valid) begin
        pc_d    = target;
        state_d = FETCH_RUN;
      end
    end else if (redirect_valid) begin
      pc_d   = target;
      bubble = 1'b1;
    end else if (!stall) begin
      if (in_range) begin
        load          = 1'b1;
        pc_d          = pc_plus2;
        fetch_count_d = &fetch_count_q ? fetch_count_q : fetch_count_q + 16'd1;
      end else begin
        bubble  = 1'b1;
        state_d = FETCH_HALT;
      end
    end
  end
  // state, PC and counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= FETCH_RUN;
      pc_q          <= RESET_PC;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      fetch_count_q <= fetch_count_d;
    end
  end
  if_id_reg #(.PW(PW), .IW(IW)) u_if_id (
    .clk        (clk),
    .reset      (reset),
    .load_i     (load),
    .bubble_i   (bubble),
    .instr_i    (imem_instr),
    .pc_i       (pc_q),
    .pc_plus2_i (pc_plus2),
    .valid_o    (if_id_valid),
    .instr_o    (if_id_instr),
    .pc_o       (if_id_pc),
    .pc_plus2_o (if_id_pc_plus2)
  );
  assign imem_pc     = pc_q;
  assign halted      = state_q == FETCH_HALT;
  assign fetch_count = fetch_count_q;
endmodule
